// File: rtl/lock_pkg.sv
// Shared types for the keypad lock: FSM state encoding, strobe decode and status colours.
// Pure declarations; no latency or flow control of its own.
package lock_pkg;

    typedef enum logic [2:0] {
        LOCKED   = 3'd0,
        FAIL     = 3'd1,
        LOCKOUT  = 3'd2,
        UNLOCKED = 3'd3,
        PROGRAM  = 3'd4
    } lock_state_e;

    // Only one strobe is acted on per cycle; the rest are dropped.
    typedef enum logic [2:0] {
        EV_NONE,
        EV_KEY,
        EV_PROG,
        EV_ENTER,
        EV_CLEAR
    } strobe_e;

    localparam logic [2:0] RGB_OFF      = 3'b000;
    localparam logic [2:0] RGB_LOCKOUT  = 3'b100;
    localparam logic [2:0] RGB_UNLOCKED = 3'b010;
    localparam logic [2:0] RGB_PROGRAM  = 3'b001;
    localparam logic [2:0] RGB_FAIL     = 3'b110;

    function automatic strobe_e pick_strobe(input logic clear, input logic enter,
                                            input logic prog, input logic key_valid);
        if (clear)          return EV_CLEAR;
        else if (enter)     return EV_ENTER;
        else if (prog)      return EV_PROG;
        else if (key_valid) return EV_KEY;
        else                return EV_NONE;
    endfunction

    function automatic logic [2:0] state_rgb(input lock_state_e s);
        case (s)
            LOCKOUT:  return RGB_LOCKOUT;
            UNLOCKED: return RGB_UNLOCKED;
            PROGRAM:  return RGB_PROGRAM;
            FAIL:     return RGB_FAIL;
            default:  return RGB_OFF;
        endcase
    endfunction

endpackage

// File: rtl/lock_tick_timer.sv
// Counts timebase ticks since the last clear and flags the tick that reaches the limit.
// done is combinational on the tick that completes the count; clear takes effect next cycle.
// No backpressure: ticks arriving while clear is held are not counted.
module lock_tick_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick,
    input  logic         clr,
    input  logic [W-1:0] limit,
    output logic         done
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    // done does not look at clr so the FSM can derive clr from its next state without a loop.
    assign done = tick && (cnt_q == limit - W'(1));

endmodule

// File: rtl/lock_entry_sequencer.sv
// Keypad code entry, password compare, attempt/lockout/auto-relock policy and password reprogram.
// All outputs registered: one cycle from sampled strobe to visible effect.
// No backpressure: strobes are single-cycle, lower-priority ones in the same cycle are dropped.
module lock_entry_sequencer
    import lock_pkg::*;
#(
    parameter int               CODE_DIGITS   = 4,
    parameter int               MAX_ATTEMPTS  = 3,
    parameter int               LOCKOUT_TICKS = 250,
    parameter int               UNLOCK_TICKS  = 125,
    parameter logic [4*CODE_DIGITS-1:0] DEFAULT_CODE = 16'h1234
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     tick_in,
    input  logic                     key_valid,
    input  logic [3:0]               key_value,
    input  logic                     enter,
    input  logic                     clear,
    input  logic                     prog,
    output logic [4*CODE_DIGITS-1:0] entry_digits,
    output logic [2:0]               digit_count,
    output logic [1:0]               attempts_left,
    output logic [2:0]               state_o,
    output logic                     unlocked,
    output logic [2:0]               rgb
);

    localparam int CW = 4 * CODE_DIGITS;
    localparam int TMAX = (LOCKOUT_TICKS > UNLOCK_TICKS) ? LOCKOUT_TICKS : UNLOCK_TICKS;
    localparam int TW = $clog2(TMAX + 1);

    lock_state_e     state_q, state_n;
    logic [CW-1:0]   buf_q, buf_n;
    logic [CW-1:0]   pw_q, pw_n;
    logic [2:0]      cnt_q, cnt_n;
    logic [1:0]      att_q, att_n;
    logic [2:0]      rgb_q, rgb_n;
    logic            unl_q, unl_n;
    strobe_e         ev;
    logic            tmr_clr;
    logic            tmr_done;
    logic [TW-1:0]   tmr_limit;
    logic            buf_full;

    assign ev       = pick_strobe(clear, enter, prog, key_valid);
    assign buf_full = (cnt_q == 3'(CODE_DIGITS));

    // One counter serves both lockout and idle-relock; it is held clear in every other state.
    assign tmr_limit = (state_q == LOCKOUT) ? TW'(LOCKOUT_TICKS) : TW'(UNLOCK_TICKS);
    assign tmr_clr   = (state_n != state_q)
                    || !((state_q == LOCKOUT) || (state_q == UNLOCKED))
                    || ((state_q == UNLOCKED) && (ev != EV_NONE));

    lock_tick_timer #(.W(TW)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .tick  (tick_in),
        .clr   (tmr_clr),
        .limit (tmr_limit),
        .done  (tmr_done)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= LOCKED;
            buf_q   <= '0;
            pw_q    <= DEFAULT_CODE;
            cnt_q   <= '0;
            att_q   <= 2'(MAX_ATTEMPTS);
            rgb_q   <= RGB_OFF;
            unl_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            buf_q   <= buf_n;
            pw_q    <= pw_n;
            cnt_q   <= cnt_n;
            att_q   <= att_n;
            rgb_q   <= rgb_n;
            unl_q   <= unl_n;
        end
    end

    always_comb begin
        state_n = state_q;
        buf_n   = buf_q;
        pw_n    = pw_q;
        cnt_n   = cnt_q;
        att_n   = att_q;
        case (state_q)
            LOCKED: begin
                case (ev)
                    EV_CLEAR: begin
                        buf_n = '0;
                        cnt_n = '0;
                    end
                    EV_ENTER: begin
                        if (buf_full) begin
                            buf_n = '0;
                            cnt_n = '0;
                            if (buf_q == pw_q) begin
                                state_n = UNLOCKED;
                                att_n   = 2'(MAX_ATTEMPTS);
                            end else if (att_q == 2'd1) begin
                                state_n = LOCKOUT;
                                att_n   = '0;
                            end else begin
                                state_n = FAIL;
                                att_n   = att_q - 2'd1;
                            end
                        end
                    end
                    EV_KEY: begin
                        if (!buf_full) begin
                            buf_n = {buf_q[CW-5:0], key_value};
                            cnt_n = cnt_q + 3'd1;
                        end
                    end
                    default: ;
                endcase
            end
            FAIL: begin
                if (tick_in) state_n = LOCKED;
            end
            LOCKOUT: begin
                if (tmr_done) begin
                    state_n = LOCKED;
                    att_n   = 2'(MAX_ATTEMPTS);
                end
            end
            UNLOCKED: begin
                case (ev)
                    EV_ENTER: state_n = LOCKED;
                    EV_PROG: begin
                        state_n = PROGRAM;
                        buf_n   = '0;
                        cnt_n   = '0;
                    end
                    EV_NONE: begin
                        if (tmr_done) state_n = LOCKED;
                    end
                    default: ;
                endcase
            end
            PROGRAM: begin
                case (ev)
                    EV_CLEAR: begin
                        state_n = UNLOCKED;
                        buf_n   = '0;
                        cnt_n   = '0;
                    end
                    EV_ENTER: begin
                        if (buf_full) begin
                            state_n = UNLOCKED;
                            pw_n    = buf_q;
                            buf_n   = '0;
                            cnt_n   = '0;
                        end
                    end
                    EV_KEY: begin
                        if (!buf_full) begin
                            buf_n = {buf_q[CW-5:0], key_value};
                            cnt_n = cnt_q + 3'd1;
                        end
                    end
                    default: ;
                endcase
            end
            default: state_n = LOCKED;
        endcase
    end

    // Status outputs are decoded from the next state so they register alongside it.
    always_comb begin
        rgb_n = state_rgb(state_n);
        unl_n = (state_n == UNLOCKED) || (state_n == PROGRAM);
    end

    assign entry_digits  = buf_q;
    assign digit_count   = cnt_q;
    assign attempts_left = att_q;
    assign state_o       = state_q;
    assign unlocked      = unl_q;
    assign rgb           = rgb_q;

endmodule

// File: tb/tb_lock_entry_sequencer.sv
// Directed scenarios then random strobes, every cycle compared with a queue-based policy model.
module tb_lock_entry_sequencer;
    import lock_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tick_in = 1'b0, key_valid = 1'b0, enter = 1'b0, clear = 1'b0, prog = 1'b0;
    logic [3:0]  key_value = 4'h0;
    logic [15:0] entry_digits;
    logic [2:0]  digit_count;
    logic [1:0]  attempts_left;
    logic [2:0]  state_o;
    logic        unlocked;
    logic [2:0]  rgb;

    always #5 clk = ~clk;

    lock_entry_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .tick_in       (tick_in),
        .key_valid     (key_valid),
        .key_value     (key_value),
        .enter         (enter),
        .clear         (clear),
        .prog          (prog),
        .entry_digits  (entry_digits),
        .digit_count   (digit_count),
        .attempts_left (attempts_left),
        .state_o       (state_o),
        .unlocked      (unlocked),
        .rgb           (rgb)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: digits as a queue, failures as a plain count, ticks since state entry.
    lock_state_e m_st = LOCKED;
    int          m_q[$];
    int          m_fails = 0;
    logic [15:0] m_pw = 16'h1234;
    int          m_ticks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] m_val();
        logic [15:0] v = 16'h0;
        foreach (m_q[i]) v = {v[11:0], 4'(m_q[i])};
        return v;
    endfunction

    function automatic logic [2:0] m_rgb(input lock_state_e s);
        if (s == LOCKOUT)       return 3'b100;
        else if (s == UNLOCKED) return 3'b010;
        else if (s == PROGRAM)  return 3'b001;
        else if (s == FAIL)     return 3'b110;
        return 3'b000;
    endfunction

    task automatic model_step(input logic t, input logic kv, input logic [3:0] kvl,
                              input logic en, input logic cl, input logic pg);
        lock_state_e nxt;
        if (!rst) begin
            m_st = LOCKED; m_q.delete(); m_fails = 0; m_pw = 16'h1234; m_ticks = 0;
            return;
        end
        nxt = m_st;
        case (m_st)
            LOCKED: begin
                if (cl) m_q.delete();
                else if (en) begin
                    if (m_q.size() == 4) begin
                        if (m_val() == m_pw) begin
                            nxt = UNLOCKED; m_fails = 0;
                        end else begin
                            m_fails++;
                            nxt = (m_fails == 3) ? LOCKOUT : FAIL;
                        end
                        m_q.delete();
                    end
                end else if (!pg && kv && m_q.size() < 4) m_q.push_back(int'(kvl));
            end
            FAIL: if (t) nxt = LOCKED;
            LOCKOUT: if (t) begin
                m_ticks++;
                if (m_ticks == 250) begin nxt = LOCKED; m_fails = 0; end
            end
            UNLOCKED: begin
                if (cl || en || pg || kv) begin
                    m_ticks = 0;
                    if (!cl && en) nxt = LOCKED;
                    else if (!cl && pg) begin nxt = PROGRAM; m_q.delete(); end
                end else if (t) begin
                    m_ticks++;
                    if (m_ticks == 125) nxt = LOCKED;
                end
            end
            PROGRAM: begin
                if (cl) begin m_q.delete(); nxt = UNLOCKED; end
                else if (en) begin
                    if (m_q.size() == 4) begin m_pw = m_val(); m_q.delete(); nxt = UNLOCKED; end
                end else if (!pg && kv && m_q.size() < 4) m_q.push_back(int'(kvl));
            end
            default: nxt = LOCKED;
        endcase
        if (nxt != m_st) m_ticks = 0;
        m_st = nxt;
    endtask

    task automatic cyc(input logic t, input logic kv, input logic [3:0] kvl,
                       input logic en, input logic cl, input logic pg);
        tick_in = t; key_valid = kv; key_value = kvl; enter = en; clear = cl; prog = pg;
        @(posedge clk);
        model_step(t, kv, kvl, en, cl, pg);
        #1;
        chk("state", 32'(state_o), 32'(m_st));
        chk("digits", 32'(entry_digits), 32'(m_val()));
        chk("count", 32'(digit_count), 32'(m_q.size()));
        chk("attempts", 32'(attempts_left), 32'(3 - m_fails));
        chk("unlocked", 32'(unlocked), 32'((m_st == UNLOCKED) || (m_st == PROGRAM)));
        chk("rgb", 32'(rgb), 32'(m_rgb(m_st)));
        tick_in = 0; key_valid = 0; enter = 0; clear = 0; prog = 0;
    endtask

    task automatic idle(input logic t);
        cyc(t, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic press(input logic [3:0] d);
        cyc(1'b0, 1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_enter();
        cyc(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic code(input logic [15:0] c);
        press(c[15:12]); press(c[11:8]); press(c[7:4]); press(c[3:0]);
    endtask

    initial begin
        // Reset
        rst = 1'b0;
        idle(1'b0); idle(1'b1);
        chk("rst_state", 32'(state_o), 32'(LOCKED));
        chk("rst_att", 32'(attempts_left), 32'd3);
        chk("rst_rgb", 32'(rgb), 32'd0);
        chk("rst_digits", 32'(entry_digits), 32'd0);
        rst = 1'b1;

        // 1: correct code unlocks
        code(16'h1234); do_enter();
        chk("t1_state", 32'(state_o), 32'(UNLOCKED));
        chk("t1_rgb", 32'(rgb), 32'b010);
        chk("t1_count", 32'(digit_count), 32'd0);
        do_enter();
        chk("t1_relock", 32'(state_o), 32'(LOCKED));

        // 2: three failures, lockout, timed release
        code(16'h9999); do_enter();
        chk("t2_fail1", 32'(state_o), 32'(FAIL));
        chk("t2_rgb", 32'(rgb), 32'b110);
        chk("t2_att1", 32'(attempts_left), 32'd2);
        idle(1'b1);
        code(16'h9999); do_enter();
        chk("t2_att2", 32'(attempts_left), 32'd1);
        idle(1'b1);
        code(16'h9999); do_enter();
        chk("t2_lockout", 32'(state_o), 32'(LOCKOUT));
        chk("t2_lo_rgb", 32'(rgb), 32'b100);
        press(4'h3);
        chk("t2_lo_key", 32'(digit_count), 32'd0);
        for (int i = 0; i < 249; i++) idle(1'b1);
        chk("t2_lo_249", 32'(state_o), 32'(LOCKOUT));
        idle(1'b1);
        chk("t2_lo_250", 32'(state_o), 32'(LOCKED));
        chk("t2_att_rst", 32'(attempts_left), 32'd3);

        // 3: buffer saturates, clear beats enter and key
        press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'h5);
        chk("t3_digits", 32'(entry_digits), 32'h1234);
        chk("t3_count", 32'(digit_count), 32'd4);
        cyc(1'b0, 1'b1, 4'h9, 1'b1, 1'b1, 1'b0);
        chk("t3_clr_digits", 32'(entry_digits), 32'd0);
        chk("t3_clr_state", 32'(state_o), 32'(LOCKED));

        // 4: reprogram password
        code(16'h1234); do_enter();
        cyc(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        chk("t4_prog", 32'(state_o), 32'(PROGRAM));
        chk("t4_prog_rgb", 32'(rgb), 32'b001);
        code(16'h7701); do_enter();
        chk("t4_saved", 32'(state_o), 32'(UNLOCKED));
        do_enter();
        code(16'h1234); do_enter();
        chk("t4_old_pw", 32'(state_o), 32'(FAIL));
        idle(1'b1);
        code(16'h7701); do_enter();
        chk("t4_new_pw", 32'(state_o), 32'(UNLOCKED));

        // 5: idle auto-relock, and a key restarting it
        for (int i = 0; i < 124; i++) idle(1'b1);
        chk("t5_124", 32'(state_o), 32'(UNLOCKED));
        idle(1'b1);
        chk("t5_125", 32'(state_o), 32'(LOCKED));
        code(16'h7701); do_enter();
        for (int i = 0; i < 100; i++) idle(1'b1);
        press(4'h5);
        for (int i = 0; i < 124; i++) idle(1'b1);
        chk("t5_224", 32'(state_o), 32'(UNLOCKED));
        idle(1'b1);
        chk("t5_225", 32'(state_o), 32'(LOCKED));

        // 6: reset in lockout and in program restores the default password
        for (int k = 0; k < 3; k++) begin code(16'h0000); do_enter(); idle(1'b1); end
        idle(1'b1);
        rst = 1'b0; idle(1'b0);
        chk("t6_lo_rst", 32'(state_o), 32'(LOCKED));
        chk("t6_lo_att", 32'(attempts_left), 32'd3);
        rst = 1'b1;
        code(16'h1234); do_enter();
        cyc(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        press(4'h5);
        rst = 1'b0; idle(1'b0);
        chk("t6_pg_rst", 32'(state_o), 32'(LOCKED));
        chk("t6_pg_cnt", 32'(digit_count), 32'd0);
        rst = 1'b1;
        code(16'h1234); do_enter();
        chk("t6_default_pw", 32'(state_o), 32'(UNLOCKED));

        // Random phase, digits biased toward the current password so unlocks occur
        for (int i = 0; i < 6000; i++) begin
            logic [3:0] d;
            int sz;
            sz = m_q.size();
            if (sz < 4 && $urandom_range(0, 3) != 0) d = m_pw[4*(3-sz) +: 4];
            else d = 4'($urandom_range(0, 15));
            rst = ($urandom_range(0, 1499) != 0);
            cyc($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, d,
                $urandom_range(0, 11) == 0, $urandom_range(0, 49) == 0,
                $urandom_range(0, 24) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
